// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Purpose  : 2-bit saturating-counter branch direction predictor (ID lookup),
//            EX-stage misprediction detection with PC redirect and a
//            multi-cycle pipeline flush sequencer, plus debug statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
  parameter int NBITS        = 32,
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_BITS     = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NBITS-1:0]    i_ID_PC,
  input  logic                i_ID_IsBranch,
  output logic                o_ID_PredTaken,
  input  logic                i_Resolve_Valid,
  input  logic [NBITS-1:0]    i_Resolve_PC,
  input  logic                i_Resolve_PredTaken,
  input  logic                i_PCSrc,
  input  logic [NBITS-1:0]    i_Resolve_Target,
  input  logic [NBITS-1:0]    i_Resolve_PCPlus4,
  output logic                o_Redirect,
  output logic [NBITS-1:0]    o_RedirectAddr,
  output logic                o_Flush,
  output logic [CNT_BITS-1:0] o_BranchCount,
  output logic [CNT_BITS-1:0] o_MispredictCount
);

  localparam int                ENTRIES    = 1 << IDX_BITS;
  localparam logic [1:0]        ST_IDLE    = 2'd0;
  localparam logic [1:0]        ST_FLUSH   = 2'd1;
  localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [1:0]          pred_table [ENTRIES];
  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [2:0]          flush_cnt;
  logic [2:0]          flush_cnt_next;
  logic [IDX_BITS-1:0] id_idx;
  logic [IDX_BITS-1:0] rs_idx;
  logic                accept;
  logic                mispredict;
  logic                redirect_q;
  logic [NBITS-1:0]    redirect_addr_q;
  logic [CNT_BITS-1:0] branch_cnt;
  logic [CNT_BITS-1:0] mispredict_cnt;

  // Word-aligned PCs: drop the two byte-offset bits when indexing.
  assign id_idx = i_ID_PC[IDX_BITS+1:2];
  assign rs_idx = i_Resolve_PC[IDX_BITS+1:2];

  // Lookup reads the registered table only, so same-cycle updates are not bypassed.
  assign o_ID_PredTaken = i_ID_IsBranch & pred_table[id_idx][1];

  // Resolutions arriving while flushing belong to squashed instructions.
  assign accept     = i_enable & i_Resolve_Valid & (state == ST_IDLE);
  assign mispredict = accept & (i_PCSrc != i_Resolve_PredTaken);

  // State register: FSM state and remaining-flush down-counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else if (i_enable) begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next-state logic: enter FLUSH on a mispredict, leave when the count reaches 1.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      ST_IDLE: begin
        if (mispredict) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == 3'd1) begin
          state_next     = ST_IDLE;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        flush_cnt_next = '0;
      end
    endcase
  end

  // Output decode: flush is asserted for every cycle spent in FLUSH.
  always_comb begin
    o_Flush = 1'b0;
    if (state == ST_FLUSH) begin
      o_Flush = 1'b1;
    end
  end

  // Predictor table: reset to weakly not-taken, saturating train on accepted resolutions.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pred_table[i] <= 2'b01;
      end
    end else if (accept) begin
      if (i_PCSrc && (pred_table[rs_idx] != 2'b11)) begin
        pred_table[rs_idx] <= pred_table[rs_idx] + 2'd1;
      end else if (!i_PCSrc && (pred_table[rs_idx] != 2'b00)) begin
        pred_table[rs_idx] <= pred_table[rs_idx] - 2'd1;
      end
    end
  end

  // Redirect strobe and captured address; the address holds between mispredicts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
    end else if (i_enable) begin
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_addr_q <= i_PCSrc ? i_Resolve_Target : i_Resolve_PCPlus4;
      end
    end
  end

  // Saturating statistics counters for the debug unit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (accept && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (mispredict && (mispredict_cnt != CNT_MAX)) begin
        mispredict_cnt <= mispredict_cnt + 1'b1;
      end
    end
  end

  assign o_Redirect        = redirect_q;
  assign o_RedirectAddr    = redirect_addr_q;
  assign o_BranchCount     = branch_cnt;
  assign o_MispredictCount = mispredict_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch direction predictor and misprediction flush sequencer for the 5-stage MIPS pipeline.
- In ID it supplies a taken/not-taken prediction from a table of 2-bit saturating counters.
- In EX it compares the resolved branch outcome (the PCSrc decision) with the prediction that travelled down the pipeline. On a mismatch it redirects the PC and sequences the pipeline flush.
- It exports branch and misprediction counters for the debug unit.

Parameters:
- NBITS, 32, width of PC and address buses.
- IDX_BITS, 4, log2 of predictor table entries (16 entries).
- FLUSH_CYCLES, 2, cycles o_Flush stays high per misprediction; legal range 1..7.
- CNT_BITS, 16, width of statistics counters.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  pipeline step enable; when 0 all registers hold.
- i_ID_PC  in  NBITS  PC of instruction in ID.
- i_ID_IsBranch  in  1  ID instruction is BEQ or BNE.
- o_ID_PredTaken  out  1  prediction for ID instruction.
- i_Resolve_Valid  in  1  EX holds a BEQ/BNE (Branch | NBranch).
- i_Resolve_PC  in  NBITS  PC of resolving branch.
- i_Resolve_PredTaken  in  1  prediction carried with that branch.
- i_PCSrc  in  1  actual outcome, 1 = taken.
- i_Resolve_Target  in  NBITS  branch target address.
- i_Resolve_PCPlus4  in  NBITS  fall-through address.
- o_Redirect  out  1  one-cycle PC redirect strobe.
- o_RedirectAddr  out  NBITS  address to load into PC when o_Redirect = 1.
- o_Flush  out  1  squash IF/ID and ID/EX contents.
- o_BranchCount  out  CNT_BITS  accepted resolutions.
- o_MispredictCount  out  CNT_BITS  accepted mispredictions.

Behaviour:
- Reset values:
  - all table entries 2'b01 (weakly not-taken);
  - FSM in IDLE;
  - o_Redirect = 0, o_RedirectAddr = 0, o_Flush = 0;
  - both counters 0.
- Table index:
  - ID lookup uses i_ID_PC[IDX_BITS+1:2].
  - Update uses i_Resolve_PC[IDX_BITS+1:2].
- Prediction is combinational: o_ID_PredTaken = i_ID_IsBranch & entry[1].
  - No bypass: a same-cycle update to the same index is not visible until the next cycle.
- Accepted resolution: i_enable & i_Resolve_Valid & (state == IDLE).
- On an accepted resolution, at the edge:
  - the counter saturates up if i_PCSrc = 1, down if i_PCSrc = 0 (11 stays 11, 00 stays 00);
  - o_BranchCount increments, saturating at all-ones.
- Mispredict = accepted resolution & (i_PCSrc != i_Resolve_PredTaken). On a mispredict at edge N:
  - o_MispredictCount increments, saturating;
  - o_RedirectAddr captures i_PCSrc ? i_Resolve_Target : i_Resolve_PCPlus4;
  - o_Redirect is high for cycle N+1 only;
  - o_Flush is high for cycles N+1 .. N+FLUSH_CYCLES;
  - FSM goes IDLE -> FLUSH with a down-counter loaded to FLUSH_CYCLES.
- FLUSH state:
  - The counter decrements each enabled cycle; at 1 the FSM returns to IDLE and o_Flush drops next cycle.
  - Resolutions in FLUSH belong to squashed instructions: no table update, no counting, no redirect.
- A correct prediction produces no redirect and no flush.
- o_RedirectAddr holds its last captured value when o_Redirect = 0.
- i_enable = 0 freezes FSM, flush counter, table, statistics counters and all registered outputs. The o_ID_PredTaken lookup remains combinational.
- i_reset takes priority over i_enable.
  - Reset mid-FLUSH returns to IDLE with o_Flush = 0 next cycle.
  - The table is reinitialised.
- Reset is checked every cycle in synthesis; no initial-block dependence.

Test Plan:
- Reset, then i_ID_PC = 0x40, i_ID_IsBranch = 1 -> o_ID_PredTaken = 0; all outputs and counters 0.
- Two accepted resolutions, PC = 0x40, i_PCSrc = 1, predicted 0 then 1:
  - first -> o_Redirect pulse with o_RedirectAddr = i_Resolve_Target (0x100); o_Flush high 2 cycles; o_MispredictCount = 1;
  - second (issued after flush) -> no redirect; entry 0x40 = 11; prediction for PC 0x40 = 1; o_BranchCount = 2.
- Predicted 1, i_PCSrc = 0, PCPlus4 = 0x48 -> o_RedirectAddr = 0x48 for one cycle; entry saturates down.
- Resolve_Valid asserted during FLUSH state -> no counter or table change, no second redirect.
- i_enable low for 3 cycles mid-flush -> o_Flush stays high; total high enabled cycles still FLUSH_CYCLES.
- i_reset asserted during FLUSH -> o_Flush = 0, counters = 0, PC 0x40 predicts 0 afterwards.
